// File: rtl/bht_predictor.sv
// bht_predictor: branch history table with 2-bit saturating counters and a registered lookup port.
//
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset
//   flush_i         clears the table by restarting the init walk
//   debug_mode_i    drops updates while high; lookups are still served
//   lookup_valid_i  lookup request for lookup_pc_i
//   lookup_pc_i     fetch PC to predict
//   pred_valid_o    registered; the looked-up entry is valid
//   pred_taken_o    registered; predicted direction
//   upd_valid_i     resolved conditional branch
//   upd_pc_i        PC of the resolved branch
//   upd_taken_i     actual outcome of the resolved branch
//   ready_o         high once the init walk has finished
//
// Optional feature: define BHT_FWD_EN so that a lookup and an update to the
// same index in the same cycle returns the post-update entry instead of the
// pre-update one.
module bht_predictor #(
    parameter int NR_ENTRIES = 1024,
    parameter int VLEN       = 64
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            debug_mode_i,
    input  logic            lookup_valid_i,
    input  logic [VLEN-1:0] lookup_pc_i,
    output logic            pred_valid_o,
    output logic            pred_taken_o,
    input  logic            upd_valid_i,
    input  logic [VLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i,
    output logic            ready_o
);
    localparam int IW = $clog2(NR_ENTRIES);

    typedef enum logic {INIT, READY} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   init_idx_q, init_idx_d;
    logic            valid_q [NR_ENTRIES];
    logic [1:0]      cnt_q   [NR_ENTRIES];
    logic [IW-1:0]   look_idx, upd_idx;
    logic            upd_en;
    logic [1:0]      upd_cnt;
    logic            look_v;
    logic [1:0]      look_cnt;
    logic            pred_valid_d;
    logic            pc_unused;

    // Halfword-granular index; the remaining PC bits do not take part.
    assign look_idx  = lookup_pc_i[IW:1];
    assign upd_idx   = upd_pc_i[IW:1];
    assign pc_unused = ^{lookup_pc_i[VLEN-1:IW+1], lookup_pc_i[0],
                         upd_pc_i[VLEN-1:IW+1], upd_pc_i[0]};

    assign ready_o = (state_q == READY);

    // Flush wins over a same-cycle update, so the update never lands.
    assign upd_en = upd_valid_i & ready_o & ~debug_mode_i & ~flush_i;

    // Fresh entries start weakly biased toward the observed outcome.
    always_comb begin
        upd_cnt = cnt_q[upd_idx];
        if (!valid_q[upd_idx])
            upd_cnt = upd_taken_i ? 2'b10 : 2'b01;
        else if (upd_taken_i)
            upd_cnt = (cnt_q[upd_idx] == 2'b11) ? 2'b11 : cnt_q[upd_idx] + 2'd1;
        else
            upd_cnt = (cnt_q[upd_idx] == 2'b00) ? 2'b00 : cnt_q[upd_idx] - 2'd1;
    end

`ifdef BHT_FWD_EN
    always_comb begin
        look_v   = valid_q[look_idx];
        look_cnt = cnt_q[look_idx];
        if (upd_en && (upd_idx == look_idx)) begin
            look_v   = 1'b1;
            look_cnt = upd_cnt;
        end
    end
`else
    always_comb begin
        look_v   = valid_q[look_idx];
        look_cnt = cnt_q[look_idx];
    end
`endif

    // A flush in this cycle forces the prediction register back to idle.
    assign pred_valid_d = lookup_valid_i & ready_o & ~flush_i & look_v;

    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        if (state_q == INIT) begin
            init_idx_d = init_idx_q + 1'b1;
            if (init_idx_q == IW'(NR_ENTRIES - 1)) begin
                state_d    = READY;
                init_idx_d = '0;
            end
        end
        if (flush_i) begin
            state_d    = INIT;
            init_idx_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= INIT;
            init_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
        end
    end

    // The table itself is not reset; the init walk clears it before READY.
    always_ff @(posedge clk_i) begin
        if (state_q == INIT) begin
            valid_q[init_idx_q] <= 1'b0;
            cnt_q[init_idx_q]   <= 2'b00;
        end else if (upd_en) begin
            valid_q[upd_idx] <= 1'b1;
            cnt_q[upd_idx]   <= upd_cnt;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pred_valid_o <= 1'b0;
            pred_taken_o <= 1'b0;
        end else begin
            pred_valid_o <= pred_valid_d;
            pred_taken_o <= pred_valid_d & look_cnt[1];
        end
    end
endmodule

// File: tb/tb_bht_predictor.sv
// tb_bht_predictor: scoreboard bench for bht_predictor against an abstract table model.
module tb_bht_predictor;
    localparam int NR = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        flush_i = 1'b0;
    logic        debug_mode_i = 1'b0;
    logic        lookup_valid_i = 1'b0;
    logic [63:0] lookup_pc_i = '0;
    logic        pred_valid_o;
    logic        pred_taken_o;
    logic        upd_valid_i = 1'b0;
    logic [63:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic        ready_o;

    bht_predictor #(.NR_ENTRIES(NR), .VLEN(64)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .debug_mode_i(debug_mode_i),
        .lookup_valid_i(lookup_valid_i), .lookup_pc_i(lookup_pc_i),
        .pred_valid_o(pred_valid_o), .pred_taken_o(pred_taken_o),
        .upd_valid_i(upd_valid_i), .upd_pc_i(upd_pc_i), .upd_taken_i(upd_taken_i),
        .ready_o(ready_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic pv;
        logic pt;
        logic rdy;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Model: -1 marks an invalid entry, otherwise the counter value 0..3.
    // walk_left counts the clearing cycles still to go before the table is usable.
    int tbl[NR];
    int walk_left = NR;

    function automatic int bump(input int c, input bit t);
        if (c < 0) return t ? 2 : 1;
        return t ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
    endfunction

    task automatic cyc(input bit r, input bit f, input bit d,
                       input bit lv, input logic [63:0] lpc,
                       input bit uv, input logic [63:0] upc, input bit ut);
        int   li, ui, e;
        bit   eff;
        exp_t x;
        rst_i = r; flush_i = f; debug_mode_i = d;
        lookup_valid_i = lv; lookup_pc_i = lpc;
        upd_valid_i = uv; upd_pc_i = upc; upd_taken_i = ut;
        li  = int'((lpc >> 1) % NR);
        ui  = int'((upc >> 1) % NR);
        eff = !r && !f && walk_left == 0 && uv && !d;
        e   = tbl[li];
`ifdef BHT_FWD_EN
        if (eff && ui == li) e = bump(tbl[ui], ut);
`endif
        x.pv = lv && !r && !f && walk_left == 0 && e >= 0;
        x.pt = x.pv && e >= 2;
        if (r || f) begin
            walk_left = NR;
            foreach (tbl[i]) tbl[i] = -1;
        end else if (walk_left > 0) begin
            walk_left--;
        end else if (eff) begin
            tbl[ui] = bump(tbl[ui], ut);
        end
        x.rdy = (walk_left == 0);
        exp_q.push_back(x);
        @(negedge clk_i);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 64'h0, 0, 64'h0, 0);
    endtask

    task automatic lk(input logic [63:0] pc);
        cyc(0, 0, 0, 1, pc, 0, 64'h0, 0);
    endtask

    task automatic up(input logic [63:0] pc, input bit t);
        cyc(0, 0, 0, 0, 64'h0, 1, pc, t);
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #1;
            if (exp_q.size() > 0) begin
                exp_t x;
                x = exp_q.pop_front();
                checks += 3;
                if (pred_valid_o !== x.pv) begin
                    failures++;
                    $display("FAIL pred_valid t=%0t got=%b want=%b", $time, pred_valid_o, x.pv);
                end
                if (pred_taken_o !== x.pt) begin
                    failures++;
                    $display("FAIL pred_taken t=%0t got=%b want=%b", $time, pred_taken_o, x.pt);
                end
                if (ready_o !== x.rdy) begin
                    failures++;
                    $display("FAIL ready t=%0t got=%b want=%b", $time, ready_o, x.rdy);
                end
            end
        end
    end

    initial begin
        foreach (tbl[i]) tbl[i] = -1;
        @(negedge clk_i);
        repeat (3) cyc(1, 0, 0, 1, 64'h8000_0000, 1, 64'h4, 1);
        idle(15);
        lk(64'h8000_0000);
        lk(64'h8000_0000);
        idle(2);
        for (int i = 0; i < 3; i++) begin
            up(64'h8000_0004, 1);
            lk(64'h8000_0004);
        end
        for (int i = 0; i < 4; i++) begin
            up(64'h8000_0004, 0);
            lk(64'h8000_0004);
        end
        up(64'h40, 1);
        lk(64'h60);
        cyc(0, 0, 0, 1, 64'h8, 1, 64'h8, 1);
        lk(64'h8);
        cyc(0, 0, 0, 1, 64'h8, 1, 64'h8, 0);
        lk(64'h8);
        cyc(0, 1, 0, 1, 64'h8, 0, 64'h0, 0);
        idle(4);
        cyc(0, 1, 0, 0, 64'h0, 1, 64'h8000_0004, 1);
        idle(NR - 1);
        lk(64'h8000_0004);
        lk(64'h8000_0004);
        cyc(0, 0, 1, 0, 64'h0, 1, 64'h10, 1);
        lk(64'h10);
        up(64'h10, 1);
        lk(64'h10);
        cyc(0, 0, 1, 1, 64'h10, 1, 64'h10, 0);
        lk(64'h10);
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 499) == 0, $urandom_range(0, 199) == 0,
                $urandom_range(0, 7) == 0, 1'($urandom),
                64'h8000_0000 + 64'($urandom_range(0, 63)), 1'($urandom),
                64'h8000_0000 + 64'($urandom_range(0, 63)), 1'($urandom));
        end
        idle(2);
        @(posedge clk_i);
        #2;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d want=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
